id_sync_fifo: RTL and testbench

Parametrised single-clock successor to the bridge's 16x9 dual-clock ID FIFO. It buffers AXI transaction IDs and control tags between the AXI slave front end and the AHB master sequencer when both sides run on one clock. Added over the previous generation:
- configurable width and depth
- selectable show-ahead or registered read mode
- occupancy level output
- programmable almost-full and almost-empty thresholds
- synchronous flush
- sticky overflow and underflow error flags

---
 rtl/id_sync_fifo.sv | 152 +++++++++++++++
 tb/tb_id_sync_fifo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_sync_fifo.sv
// id_sync_fifo
//   Single-clock FIFO carrying AXI transaction IDs and control tags from the
//   AXI slave front end to the AHB master sequencer.
//
// Ports
//   clk          rising-edge clock
//   resetn       synchronous reset, active low
//   flush        synchronous clear of contents, pointers and error flags
//   data_in      write data (DATA_W bits)
//   write_en     write request, accepted when not full and not flushing
//   read_en      read request, accepted when not empty and not flushing
//   data_out     read data: head entry (SHOWAHEAD=1) or last read entry (SHOWAHEAD=0)
//   rd_valid     data_out holds a valid entry
//   full/empty   level == DEPTH / level == 0
//   almost_full  level >= AFULL_THR
//   almost_empty level <= AEMPTY_THR
//   level        occupancy, 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
module id_sync_fifo #(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned SHOWAHEAD  = 1,
  parameter int unsigned AFULL_THR  = 12,
  parameter int unsigned AEMPTY_THR = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_en,
  input  logic              read_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned     DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_L  = (ADDR_W + 1)'(AFULL_THR);
  localparam logic [ADDR_W:0] AEMPTY_L = (ADDR_W + 1)'(AEMPTY_THR);

  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]   level_w;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Status comes from the registered pointers only; the extra pointer bit
  // makes level == DEPTH distinguishable from level == 0 after wrap.
  always_comb begin
    level_w      = wptr_q - rptr_q;
    full         = (level_w == DEPTH_L);
    empty        = (level_w == '0);
    almost_full  = (level_w >= AFULL_L);
    almost_empty = (level_w <= AEMPTY_L);
    wr_ok        = write_en & ~full & ~flush;
    rd_ok        = read_en & ~empty & ~flush;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else begin
      if (wr_ok)              wptr_d = wptr_q + 1'b1;
      if (rd_ok)              rptr_d = rptr_q + 1'b1;
      if (write_en && full)   ovf_d  = 1'b1;
      if (read_en && empty)   udf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (resetn && wr_ok) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= data_in;
    end
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      always_comb begin
        data_out = empty ? '0 : mem_q[rptr_q[ADDR_W-1:0]];
        rd_valid = ~empty;
      end
    end else begin : g_registered
      logic [DATA_W-1:0] dout_q, dout_d;
      logic              rv_q, rv_d;

      always_comb begin
        dout_d = dout_q;
        rv_d   = 1'b0;
        if (flush) begin
          dout_d = '0;
        end else if (rd_ok) begin
          dout_d = mem_q[rptr_q[ADDR_W-1:0]];
          rv_d   = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!resetn) begin
          dout_q <= '0;
          rv_q   <= 1'b0;
        end else begin
          dout_q <= dout_d;
          rv_q   <= rv_d;
        end
      end

      always_comb begin
        data_out = dout_q;
        rd_valid = rv_q;
      end
    end
  endgenerate

  always_comb begin
    level     = level_w;
    overflow  = ovf_q;
    underflow = udf_q;
  end

endmodule

// File: tb/tb_id_sync_fifo.sv
// Testbench for id_sync_fifo: one show-ahead instance with default parameters
// and one registered-read instance, sharing clock, reset and flush.
module tb_id_sync_fifo;

  logic       clk = 1'b0;
  logic       resetn, flush;
  // show-ahead instance
  logic [8:0] din, dout;
  logic       we, re, rv, full, empty, af, ae, ovf, udf;
  logic [4:0] lvl;
  // registered-read instance
  logic [8:0] r_din, r_dout;
  logic       r_we, r_re, r_rv, r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic [4:0] r_lvl;

  int checks   = 0;
  int failures = 0;
  logic [8:0] q[$];

  always #5 clk = ~clk;

  id_sync_fifo #(.DATA_W(9), .ADDR_W(4), .SHOWAHEAD(1), .AFULL_THR(12), .AEMPTY_THR(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .data_in(din), .write_en(we), .read_en(re),
    .data_out(dout), .rd_valid(rv), .full(full), .empty(empty), .almost_full(af),
    .almost_empty(ae), .level(lvl), .overflow(ovf), .underflow(udf));

  id_sync_fifo #(.DATA_W(9), .ADDR_W(4), .SHOWAHEAD(0), .AFULL_THR(12), .AEMPTY_THR(2)) dut_r (
    .clk(clk), .resetn(resetn), .flush(flush), .data_in(r_din), .write_en(r_we), .read_en(r_re),
    .data_out(r_dout), .rd_valid(r_rv), .full(r_full), .empty(r_empty), .almost_full(r_af),
    .almost_empty(r_ae), .level(r_lvl), .overflow(r_ovf), .underflow(r_udf));

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0;
    we = 1'b0; re = 1'b0; din = '0;
    r_we = 1'b0; r_re = 1'b0; r_din = '0;
    tick(); tick();
    checks++;
    if ({lvl, empty, full, ae, af, rv, ovf, udf} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_flags got lvl=%0d e=%b f=%b ae=%b af=%b rv=%b ov=%b un=%b want lvl=0 e=1 f=0 ae=1 af=0 rv=0 ov=0 un=0",
               lvl, empty, full, ae, af, rv, ovf, udf);
    end
    checks++;
    if ({dout, r_dout, r_rv, r_lvl, r_empty} !== {9'h0, 9'h0, 1'b0, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_data got dout=%h r_dout=%h r_rv=%b r_lvl=%0d r_e=%b want 0 0 0 0 1",
               dout, r_dout, r_rv, r_lvl, r_empty);
    end
    resetn = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      din = 9'h101 + 9'(i); we = 1'b1;
      tick();
      checks++;
      if ({lvl, af, ae, full} !== {5'(i + 1), (i + 1 >= 12), (i + 1 <= 2), (i + 1 == 16)}) begin
        failures++;
        $display("FAIL fill_status[%0d] got lvl=%0d af=%b ae=%b f=%b want lvl=%0d af=%b ae=%b f=%b",
                 i, lvl, af, ae, full, i + 1, (i + 1 >= 12), (i + 1 <= 2), (i + 1 == 16));
      end
    end
    din = 9'h1FF;
    tick();
    we = 1'b0;
    checks++;
    if ({ovf, lvl, full} !== {1'b1, 5'd16, 1'b1}) begin
      failures++;
      $display("FAIL overflow_write got ov=%b lvl=%0d f=%b want ov=1 lvl=16 f=1", ovf, lvl, full);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({rv, dout} !== {1'b1, 9'h101 + 9'(i)}) begin
        failures++;
        $display("FAIL drain_data[%0d] got rv=%b dout=%h want rv=1 dout=%h", i, rv, dout, 9'h101 + 9'(i));
      end
      re = 1'b1;
      tick();
    end
    re = 1'b0;
    checks++;
    if ({empty, lvl, dout, rv, udf} !== {1'b1, 5'd0, 9'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL drain_end got e=%b lvl=%0d dout=%h rv=%b un=%b want e=1 lvl=0 dout=0 rv=0 un=0",
               empty, lvl, dout, rv, udf);
    end
  endtask

  task automatic test_wrap();
    do_flush();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        din = 9'h020 + 9'(r * 16 + i); we = 1'b1;
        tick();
        checks++;
        if ({lvl, full, empty} !== {5'(i + 1), 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL wrap_wr[%0d.%0d] got lvl=%0d f=%b e=%b want lvl=%0d f=0 e=0", r, i, lvl, full, empty, i + 1);
        end
      end
      we = 1'b0;
      for (int i = 0; i < 10; i++) begin
        checks++;
        if ({dout, lvl, empty} !== {9'h020 + 9'(r * 16 + i), 5'(10 - i), 1'b0}) begin
          failures++;
          $display("FAIL wrap_rd[%0d.%0d] got dout=%h lvl=%0d e=%b want dout=%h lvl=%0d e=0",
                   r, i, dout, lvl, empty, 9'h020 + 9'(r * 16 + i), 10 - i);
        end
        re = 1'b1;
        tick();
      end
      re = 1'b0;
    end
    checks++;
    if ({empty, lvl} !== {1'b1, 5'd0}) begin
      failures++;
      $display("FAIL wrap_end got e=%b lvl=%0d want e=1 lvl=0", empty, lvl);
    end
  endtask

  task automatic test_back_to_back();
    do_flush();
    for (int i = 0; i < 5; i++) begin
      din = 9'h030 + 9'(i); we = 1'b1;
      tick();
      q.push_back(9'h030 + 9'(i));
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (dout !== q[0]) begin
        failures++;
        $display("FAIL b2b_data[%0d] got %h want %h", k, dout, q[0]);
      end
      din = 9'h040 + 9'(k); we = 1'b1; re = 1'b1;
      tick();
      void'(q.pop_front());
      q.push_back(9'h040 + 9'(k));
      checks++;
      if (lvl !== 5'd5) begin
        failures++;
        $display("FAIL b2b_level[%0d] got %0d want 5", k, lvl);
      end
    end
    re = 1'b0;
    for (int i = 0; i < 11; i++) begin
      din = 9'h060 + 9'(i);
      tick();
      q.push_back(9'h060 + 9'(i));
    end
    checks++;
    if ({full, lvl} !== {1'b1, 5'd16}) begin
      failures++;
      $display("FAIL b2b_full got f=%b lvl=%0d want f=1 lvl=16", full, lvl);
    end
    din = 9'h1EE; re = 1'b1;
    tick();
    void'(q.pop_front());
    we = 1'b0; re = 1'b0;
    checks++;
    if ({lvl, ovf, full} !== {5'd15, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL full_rw got lvl=%0d ov=%b f=%b want lvl=15 ov=1 f=0", lvl, ovf, full);
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (dout !== q[0]) begin
        failures++;
        $display("FAIL full_drain[%0d] got %h want %h", i, dout, q[0]);
      end
      re = 1'b1;
      tick();
      void'(q.pop_front());
    end
    re = 1'b0;
    checks++;
    if ({empty, ovf} !== {1'b1, 1'b1}) begin
      failures++;
      $display("FAIL full_drain_end got e=%b ov=%b want e=1 ov=1", empty, ovf);
    end
  endtask

  task automatic test_registered_read();
    r_din = 9'h0AA; r_we = 1'b1;
    tick();
    r_din = 9'h0BB;
    tick();
    r_we = 1'b0;
    checks++;
    if ({r_rv, r_lvl} !== {1'b0, 5'd2}) begin
      failures++;
      $display("FAIL reg_idle got rv=%b lvl=%0d want rv=0 lvl=2", r_rv, r_lvl);
    end
    r_re = 1'b1;
    tick();
    checks++;
    if ({r_rv, r_dout} !== {1'b1, 9'h0AA}) begin
      failures++;
      $display("FAIL reg_rd0 got rv=%b dout=%h want rv=1 dout=0aa", r_rv, r_dout);
    end
    tick();
    r_re = 1'b0;
    checks++;
    if ({r_rv, r_dout} !== {1'b1, 9'h0BB}) begin
      failures++;
      $display("FAIL reg_rd1 got rv=%b dout=%h want rv=1 dout=0bb", r_rv, r_dout);
    end
    tick();
    checks++;
    if ({r_rv, r_dout, r_empty} !== {1'b0, 9'h0BB, 1'b1}) begin
      failures++;
      $display("FAIL reg_hold got rv=%b dout=%h e=%b want rv=0 dout=0bb e=1", r_rv, r_dout, r_empty);
    end
  endtask

  task automatic test_underflow_flush();
    re = 1'b1;
    tick();
    re = 1'b0;
    checks++;
    if ({udf, dout, lvl, empty} !== {1'b1, 9'h0, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL underflow got un=%b dout=%h lvl=%0d e=%b want un=1 dout=0 lvl=0 e=1", udf, dout, lvl, empty);
    end
    for (int i = 0; i < 7; i++) begin
      din = 9'h050 + 9'(i); we = 1'b1;
      tick();
    end
    din = 9'h1AB; flush = 1'b1;
    tick();
    flush = 1'b0; we = 1'b0;
    checks++;
    if ({lvl, empty, ovf, udf, rv} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flush got lvl=%0d e=%b ov=%b un=%b rv=%b want lvl=0 e=1 ov=0 un=0 rv=0", lvl, empty, ovf, udf, rv);
    end
    din = 9'h077; we = 1'b1;
    tick();
    we = 1'b0;
    checks++;
    if ({lvl, dout} !== {5'd1, 9'h077}) begin
      failures++;
      $display("FAIL post_flush got lvl=%0d dout=%h want lvl=1 dout=077", lvl, dout);
    end
    re = 1'b1;
    tick();
    re = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_flush();
    for (int i = 0; i < 9; i++) begin
      din = 9'h080 + 9'(i); we = 1'b1;
      tick();
    end
    checks++;
    if (lvl !== 5'd9) begin
      failures++;
      $display("FAIL burst_level got %0d want 9", lvl);
    end
    din = 9'h099; resetn = 1'b0;
    tick();
    checks++;
    if ({lvl, empty, full, ae, af, rv, ovf, udf, dout} !==
        {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0}) begin
      failures++;
      $display("FAIL midburst_reset got lvl=%0d e=%b f=%b ae=%b af=%b rv=%b ov=%b un=%b dout=%h want 0 1 0 1 0 0 0 0 0",
               lvl, empty, full, ae, af, rv, ovf, udf, dout);
    end
    resetn = 1'b1; din = 9'h0C3;
    tick();
    we = 1'b0;
    checks++;
    if ({lvl, dout, rv} !== {5'd1, 9'h0C3, 1'b1}) begin
      failures++;
      $display("FAIL post_reset_wr got lvl=%0d dout=%h rv=%b want lvl=1 dout=0c3 rv=1", lvl, dout, rv);
    end
    re = 1'b1;
    tick();
    re = 1'b0;
    checks++;
    if ({empty, lvl, dout} !== {1'b1, 5'd0, 9'h0}) begin
      failures++;
      $display("FAIL post_reset_rd got e=%b lvl=%0d dout=%h want e=1 lvl=0 dout=0", empty, lvl, dout);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_back_to_back();
    test_registered_read();
    test_underflow_flush();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
